decode_queue: RTL and testbench
===============================

Name: decode_queue

Overview:
- Parametrised successor of the single-register decode stage.
- Buffers fetched {PC, INST} pairs in a DEPTH-entry FIFO with valid/ready handshakes on both sides, and decodes the head entry.
- Adds selectable sign-extended immediates and an illegal-opcode flag.
- Sits between fetch and execute; absorbs fetch/execute rate mismatch without stalling fetch on every back-pressure cycle.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- SIGN_EXT, 1, 1 = sign-extend I/S/B/J immediates from the instruction sign bit; 0 = zero-extend (legacy behaviour).
- NOP_INST, 32'h0000_0013, instruction decoded when the queue is empty.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- FLUSH  in  1  discard all queued entries.
- MEM_WAIT  in  1  global freeze; highest priority after reset.
- IN_VALID  in  1  PC/INST valid from fetch.
- IN_READY  out  1  queue accepts an entry this cycle.
- PC  in  32  fetch PC.
- INST  in  32  fetched instruction.
- OUT_VALID  out  1  head entry valid.
- OUT_READY  in  1  execute consumes the head entry.
- DECODE_PC  out  32  head PC.
- DECODE_OPCODE  out  17  {inst[6:0], inst[14:12], inst[31:25]}.
- DECODE_RD  out  5  inst[11:7].
- DECODE_RS1  out  5  inst[19:15].
- DECODE_RS2  out  5  inst[24:20].
- DECODE_CSR  out  12  inst[31:20].
- DECODE_IMM  out  32  immediate, see below.
- DECODE_ILLEGAL  out  1  head opcode not recognised.
- COUNT  out  $clog2(DEPTH)+1  occupancy.

Behaviour:
- Storage:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Registered COUNT, range 0..DEPTH.
- Reset (RST_N low, asynchronous): pointers = 0, COUNT = 0, OUT_VALID = 0, IN_READY = 0 while RST_N is low. Outputs show the NOP_INST decode with DECODE_PC = 0.
- IN_READY = RST_N && !MEM_WAIT && (COUNT != DEPTH). Combinational from registered state; no dependence on OUT_READY.
- OUT_VALID = (COUNT != 0).
- Push = IN_VALID && IN_READY && !FLUSH.
- Pop = OUT_VALID && OUT_READY && !MEM_WAIT && !FLUSH.
- Priority per edge: reset > MEM_WAIT (no state change; FLUSH ignored, so the requester holds FLUSH) > FLUSH (pointers = 0, COUNT = 0, input this cycle dropped) > push/pop.
- Simultaneous push and pop: both occur, COUNT unchanged. At COUNT = DEPTH, push is blocked by IN_READY even when popping.
- Latency: an entry pushed at edge N is at the output (OUT_VALID = 1) after edge N; there is no same-cycle bypass.
- Decode: purely combinational from the head entry. When COUNT = 0, decode uses {PC = 0, INST = NOP_INST}.
- Immediate formats (x = sign bit inst[31] if SIGN_EXT, else 0):
  - I-type (1100111, 0000011, 0010011, 0001111, 1110011): {{20{x}}, inst[31:20]}.
  - S-type (0100011): {{20{x}}, inst[31:25], inst[11:7]}.
  - B-type (1100011): {{19{x}}, inst[31], inst[7], inst[30:25], inst[11:8], 0}.
  - U-type (0110111, 0010111): {inst[31:12], 12'b0}, independent of SIGN_EXT.
  - J-type (1101111): {{11{x}}, inst[31], inst[19:12], inst[20], inst[30:21], 0}.
  - R-type (0110011): 0.
  - Any other opcode: DECODE_IMM = 0, DECODE_ILLEGAL = 1.
- DECODE_ILLEGAL is 0 when COUNT = 0.
- FLUSH while empty: no effect. FLUSH with IN_VALID: the entry is not stored.
- Reset asserted mid-operation: queue emptied immediately, with no clock required.

Test Plan:
- Reset, then push 0xFFF10093 at PC 0x100, SIGN_EXT=1 -> next cycle OUT_VALID=1, DECODE_PC=0x100, DECODE_OPCODE=0x04C7F, RD=1, RS1=2, IMM=0xFFFFFFFF, CSR=0xFFF, ILLEGAL=0.
- Push 0xFE000EE3 (beq -4) and 0xFF9FF06F (jal -8) -> IMM=0xFFFFFFFC then 0xFFFFFFF8. With SIGN_EXT=0: 0x00001FFC and 0x001FFFF8.
- DEPTH=4, OUT_READY=0, IN_VALID held for 6 cycles -> COUNT reaches 4, IN_READY=0, entries 5-6 not stored. Raise OUT_READY -> 4 entries leave in order, one per cycle.
- Simultaneous push/pop at COUNT=2 for 10 cycles -> COUNT stays 2, order preserved across pointer wrap.
- COUNT=3 with FLUSH and IN_VALID asserted -> next cycle COUNT=0, OUT_VALID=0, outputs show NOP_INST. FLUSH together with MEM_WAIT -> COUNT stays 3.
- Push 0x00000000 -> ILLEGAL=1, IMM=0. RST_N pulsed low between clock edges at COUNT=2 -> COUNT=0 and OUT_VALID=0 immediately.

Source files
------------

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry FIFO of fetched {PC, INST} pairs between fetch
// and execute, with a combinational decode of the head entry.
//
// Ports
//   CLK, RST_N         clock, asynchronous active-low reset
//   FLUSH              discard every queued entry (ignored during MEM_WAIT)
//   MEM_WAIT           global freeze: no push, no pop, no flush
//   IN_VALID/IN_READY  fetch-side handshake, PC/INST payload
//   OUT_VALID/OUT_READY execute-side handshake on the head entry
//   DECODE_*           fields of the head entry (NOP_INST at PC 0 when empty)
//   COUNT              registered occupancy, 0..DEPTH
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; IN_READY depends only on registered state, RST_N and MEM_WAIT,
// never on OUT_READY, so a full queue refuses input even while it pops.
module decode_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter bit          SIGN_EXT = 1'b1,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     FLUSH,
  input  logic                     MEM_WAIT,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic [31:0]              PC,
  input  logic [31:0]              INST,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [31:0]              DECODE_PC,
  output logic [16:0]              DECODE_OPCODE,
  output logic [4:0]               DECODE_RD,
  output logic [4:0]               DECODE_RS1,
  output logic [4:0]               DECODE_RS2,
  output logic [11:0]              DECODE_CSR,
  output logic [31:0]              DECODE_IMM,
  output logic                     DECODE_ILLEGAL,
  output logic [$clog2(DEPTH):0]   COUNT
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   pc_mem_q   [DEPTH];
  logic [31:0]   inst_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;

  assign IN_READY  = RST_N && !MEM_WAIT && (count_q != FULL);
  assign OUT_VALID = (count_q != '0);
  assign COUNT     = count_q;

  assign push = IN_VALID && IN_READY && !FLUSH;
  assign pop  = OUT_VALID && OUT_READY && !MEM_WAIT && !FLUSH;

  // MEM_WAIT freezes everything, including a pending FLUSH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (MEM_WAIT) begin
      // hold
    end else if (FLUSH) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: it is only read while COUNT != 0.
  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]   <= PC;
      inst_mem_q[wr_ptr_q] <= INST;
    end
  end

  logic [31:0] head_pc;
  logic [31:0] head_inst;
  logic        sx;
  logic        illegal_op;

  assign head_pc   = OUT_VALID ? pc_mem_q[rd_ptr_q]   : 32'h0;
  assign head_inst = OUT_VALID ? inst_mem_q[rd_ptr_q] : NOP_INST;
  assign sx        = SIGN_EXT ? head_inst[31] : 1'b0;

  assign DECODE_PC      = head_pc;
  assign DECODE_OPCODE  = {head_inst[6:0], head_inst[14:12], head_inst[31:25]};
  assign DECODE_RD      = head_inst[11:7];
  assign DECODE_RS1     = head_inst[19:15];
  assign DECODE_RS2     = head_inst[24:20];
  assign DECODE_CSR     = head_inst[31:20];
  assign DECODE_ILLEGAL = OUT_VALID && illegal_op;

  always_comb begin
    DECODE_IMM = 32'h0;
    illegal_op = 1'b0;
    case (head_inst[6:0])
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011:
        DECODE_IMM = {{20{sx}}, head_inst[31:20]};
      7'b0100011:
        DECODE_IMM = {{20{sx}}, head_inst[31:25], head_inst[11:7]};
      7'b1100011:
        DECODE_IMM = {{19{sx}}, head_inst[31], head_inst[7], head_inst[30:25],
                      head_inst[11:8], 1'b0};
      7'b0110111, 7'b0010111:
        DECODE_IMM = {head_inst[31:12], 12'h000};
      7'b1101111:
        DECODE_IMM = {{11{sx}}, head_inst[31], head_inst[19:12], head_inst[20],
                      head_inst[30:21], 1'b0};
      7'b0110011:
        DECODE_IMM = 32'h0;
      default:
        illegal_op = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_decode_queue.sv
// Bench for decode_queue: two instances (SIGN_EXT=1 and SIGN_EXT=0) share
// all inputs and are compared every cycle against a queue-based model.
module tb_decode_queue;

  localparam int          DEPTH = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, mem_wait, in_valid, out_ready;
  logic [31:0] pc, inst;

  logic        a_ir, a_ov, a_ill, b_ir, b_ov, b_ill;
  logic [31:0] a_pc, a_imm, b_pc, b_imm;
  logic [16:0] a_opc, b_opc;
  logic [4:0]  a_rd, a_rs1, a_rs2, b_rd, b_rs1, b_rs2;
  logic [11:0] a_csr, b_csr;
  logic [2:0]  a_cnt, b_cnt;

  decode_queue #(.DEPTH(DEPTH), .SIGN_EXT(1'b1), .NOP_INST(NOP)) dut_a (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .MEM_WAIT(mem_wait),
    .IN_VALID(in_valid), .IN_READY(a_ir), .PC(pc), .INST(inst),
    .OUT_VALID(a_ov), .OUT_READY(out_ready), .DECODE_PC(a_pc),
    .DECODE_OPCODE(a_opc), .DECODE_RD(a_rd), .DECODE_RS1(a_rs1),
    .DECODE_RS2(a_rs2), .DECODE_CSR(a_csr), .DECODE_IMM(a_imm),
    .DECODE_ILLEGAL(a_ill), .COUNT(a_cnt));

  decode_queue #(.DEPTH(DEPTH), .SIGN_EXT(1'b0), .NOP_INST(NOP)) dut_b (
    .CLK(clk), .RST_N(rst_n), .FLUSH(flush), .MEM_WAIT(mem_wait),
    .IN_VALID(in_valid), .IN_READY(b_ir), .PC(pc), .INST(inst),
    .OUT_VALID(b_ov), .OUT_READY(out_ready), .DECODE_PC(b_pc),
    .DECODE_OPCODE(b_opc), .DECODE_RD(b_rd), .DECODE_RS1(b_rs1),
    .DECODE_RS2(b_rs2), .DECODE_CSR(b_csr), .DECODE_IMM(b_imm),
    .DECODE_ILLEGAL(b_ill), .COUNT(b_cnt));

  // ---------------- scoreboard ----------------
  logic [63:0] exp_q[$];   // {pc, inst}, head at index 0
  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] i, input bit sx);
    longint v;
    v = 0;
    case (i[6:0])
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011: begin
        v = i[31:20];
        if (sx && i[31]) v = v - 4096;
      end
      7'b0100011: begin
        v = {i[31:25], i[11:7]};
        if (sx && i[31]) v = v - 4096;
      end
      7'b1100011: begin
        v = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (sx && i[31]) v = v - 8192;
      end
      7'b0110111, 7'b0010111: v = longint'(i[31:12]) * 4096;
      7'b1101111: begin
        v = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        if (sx && i[31]) v = v - 2097152;
      end
      default: v = 0;
    endcase
    return v[31:0];
  endfunction

  function automatic bit ref_legal(input logic [31:0] i);
    case (i[6:0])
      7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011,
      7'b0100011, 7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
      7'b0110011: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  task automatic check_dut(input string t, input bit sx, input logic ir, input logic ov,
                           input logic [2:0] cnt, input logic [31:0] dpc,
                           input logic [16:0] opc, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [11:0] csr, input logic [31:0] imm,
                           input logic ill);
    logic [31:0] hp, hi;
    bit has;
    has = (exp_q.size() > 0);
    hp  = has ? exp_q[0][63:32] : 32'h0;
    hi  = has ? exp_q[0][31:0]  : NOP;
    chk({t, "_in_ready"}, 32'(ir), 32'(rst_n && !mem_wait && exp_q.size() != DEPTH));
    chk({t, "_out_valid"}, 32'(ov), 32'(has));
    chk({t, "_count"}, 32'(cnt), exp_q.size());
    chk({t, "_pc"}, dpc, hp);
    chk({t, "_opcode"}, 32'(opc), 32'({hi[6:0], hi[14:12], hi[31:25]}));
    chk({t, "_rd"}, 32'(rd), 32'(hi[11:7]));
    chk({t, "_rs1"}, 32'(rs1), 32'(hi[19:15]));
    chk({t, "_rs2"}, 32'(rs2), 32'(hi[24:20]));
    chk({t, "_csr"}, 32'(csr), 32'(hi[31:20]));
    chk({t, "_imm"}, imm, ref_imm(hi, sx));
    chk({t, "_illegal"}, 32'(ill), 32'(has && !ref_legal(hi)));
  endtask

  task automatic check_all();
    check_dut("sx1", 1'b1, a_ir, a_ov, a_cnt, a_pc, a_opc, a_rd, a_rs1, a_rs2, a_csr, a_imm, a_ill);
    check_dut("sx0", 1'b0, b_ir, b_ov, b_cnt, b_pc, b_opc, b_rd, b_rs1, b_rs2, b_csr, b_imm, b_ill);
  endtask

  // Model of one rising edge, from the inputs applied during the cycle.
  task automatic model_edge();
    bit do_push, do_pop;
    if (!rst_n) exp_q.delete();
    else if (mem_wait) begin
    end else if (flush) exp_q.delete();
    else begin
      do_push = in_valid && (exp_q.size() < DEPTH);
      do_pop  = out_ready && (exp_q.size() > 0);
      if (do_pop)  void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({pc, inst});
    end
  endtask

  // Called at posedge+1 with inputs already set: check, advance one edge.
  task automatic tick();
    #1;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic v, input logic [31:0] p, input logic [31:0] i, input logic r);
    in_valid  = v;
    pc        = p;
    inst      = i;
    out_ready = r;
  endtask

  function automatic logic [31:0] rand_inst();
    logic [6:0] ops [12];
    logic [31:0] r;
    ops = '{7'b1100111, 7'b0000011, 7'b0010011, 7'b0001111, 7'b1110011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b0110011, 7'b1111111};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; flush = 1'b0; mem_wait = 1'b0;
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    @(posedge clk); #1;

    // reset state
    tick(); tick();
    chk("rst_count", 32'(a_cnt), 32'd0);
    chk("rst_in_ready", 32'(a_ir), 32'd0);
    chk("rst_nop_opcode", 32'(a_opc), 32'h04C00);
    rst_n = 1'b1;
    tick();

    // addi x1, x2, -1
    set_in(1'b1, 32'h100, 32'hFFF1_0093, 1'b0);
    tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    chk("lit_pc", a_pc, 32'h100);
    chk("lit_opcode", 32'(a_opc), 32'h04C7F);
    chk("lit_rd", 32'(a_rd), 32'd1);
    chk("lit_rs1", 32'(a_rs1), 32'd2);
    chk("lit_imm_sx1", a_imm, 32'hFFFF_FFFF);
    chk("lit_imm_sx0", b_imm, 32'h0000_0FFF);
    chk("lit_csr", 32'(a_csr), 32'hFFF);
    chk("lit_illegal", 32'(a_ill), 32'd0);
    out_ready = 1'b1;
    tick();

    // beq -4, jal -8
    set_in(1'b1, 32'h300, 32'hFE00_0EE3, 1'b0); tick();
    set_in(1'b1, 32'h304, 32'hFF9F_F06F, 1'b0); tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b1);
    chk("lit_beq_sx1", a_imm, 32'hFFFF_FFFC);
    chk("lit_beq_sx0", b_imm, 32'h0000_1FFC);
    tick();
    chk("lit_jal_sx1", a_imm, 32'hFFFF_FFF8);
    chk("lit_jal_sx0", b_imm, 32'h001F_FFF8);
    tick();

    // fill past full, then drain in order
    for (int k = 0; k < 6; k++) begin
      set_in(1'b1, 32'h200 + 32'(4 * k), {$urandom_range(0, 32'h1FFFFFF), 7'b0010011}, 1'b0);
      tick();
    end
    set_in(1'b0, 32'h0, 32'h0, 1'b1);
    chk("lit_full_count", 32'(a_cnt), 32'd4);
    chk("lit_full_ready", 32'(a_ir), 32'd0);
    for (int k = 0; k < 4; k++) begin
      chk("lit_drain_pc", a_pc, 32'h200 + 32'(4 * k));
      tick();
    end
    chk("lit_drained", 32'(a_cnt), 32'd0);

    // steady push+pop at COUNT=2 across pointer wrap
    for (int k = 0; k < 2; k++) begin
      set_in(1'b1, 32'h400 + 32'(4 * k), rand_inst(), 1'b0); tick();
    end
    for (int k = 2; k < 12; k++) begin
      set_in(1'b1, 32'h400 + 32'(4 * k), rand_inst(), 1'b1); tick();
      chk("lit_pp_count", 32'(a_cnt), 32'd2);
      chk("lit_pp_pc", a_pc, 32'h400 + 32'(4 * (k - 1)));
    end

    // flush with mem_wait holds, flush alone empties and drops input
    set_in(1'b1, 32'h600, rand_inst(), 1'b0); tick();
    chk("lit_pre_flush", 32'(a_cnt), 32'd3);
    flush = 1'b1; mem_wait = 1'b1;
    set_in(1'b1, 32'h604, rand_inst(), 1'b1); tick();
    chk("lit_flush_wait", 32'(a_cnt), 32'd3);
    mem_wait = 1'b0; tick();
    chk("lit_flush_count", 32'(a_cnt), 32'd0);
    chk("lit_flush_valid", 32'(a_ov), 32'd0);
    chk("lit_flush_nop", 32'(a_opc), 32'h04C00);
    flush = 1'b0;

    // illegal all-zero instruction
    set_in(1'b1, 32'h500, 32'h0, 1'b0); tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b1);
    chk("lit_ill_flag", 32'(a_ill), 32'd1);
    chk("lit_ill_imm", a_imm, 32'd0);
    tick();

    // random traffic
    for (int k = 0; k < 400; k++) begin
      flush    = ($urandom_range(0, 19) == 0);
      mem_wait = ($urandom_range(0, 6) == 0);
      set_in(1'($urandom_range(0, 9) < 6), $urandom, rand_inst(), 1'($urandom_range(0, 1)));
      tick();
    end

    // asynchronous reset at COUNT=2
    flush = 1'b1; mem_wait = 1'b0; set_in(1'b0, 32'h0, 32'h0, 1'b0); tick();
    flush = 1'b0;
    set_in(1'b1, 32'h700, rand_inst(), 1'b0); tick();
    set_in(1'b1, 32'h704, rand_inst(), 1'b0); tick();
    set_in(1'b0, 32'h0, 32'h0, 1'b0);
    chk("lit_pre_rst", 32'(a_cnt), 32'd2);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check_all();
    chk("lit_arst_count", 32'(a_cnt), 32'd0);
    chk("lit_arst_valid", 32'(a_ov), 32'd0);
    @(posedge clk); #1;
    tick();
    rst_n = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
